// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_frame
// Brief   : Parametrised UART transmitter, LSB-first, per-frame parity and
//           stop-bit selection, valid/ready input with one-word holding slot.
// Revision: 1.0 - initial release
// ============================================================================

module uart_tx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  input  logic                 i_two_stop,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic                 o_done_bit,
  output logic                 o_tx_data
);

  localparam int c_CNT_W = $clog2(OVERSAMPLE);
  localparam int c_IDX_W = $clog2(DATA_BITS);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(OVERSAMPLE - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
  localparam logic [2:0] c_ST_PARITY = 3'd3;
  localparam logic [2:0] c_ST_STOP   = 3'd4;

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 2 || OVERSAMPLE > 256) begin : g_param_check
      $error("uart_tx_frame: DATA_BITS must be 5..9 and OVERSAMPLE 2..256");
    end
  endgenerate

  logic [2:0]           r_state;
  logic [c_CNT_W-1:0]   r_tick_cnt;
  logic [c_IDX_W-1:0]   r_bit_idx;
  logic                 r_stop_second;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_en;
  logic                 r_par_bit;
  logic                 r_two_stop;
  logic [DATA_BITS-1:0] r_hold_data;
  logic                 r_hold_par_en;
  logic                 r_hold_par_bit;
  logic                 r_hold_two_stop;
  logic                 r_hold_full;
  logic                 r_tx;

  logic [2:0]           w_state_nxt;
  logic [c_CNT_W-1:0]   w_tick_cnt_nxt;
  logic [c_IDX_W-1:0]   w_bit_idx_nxt;
  logic                 w_stop_second_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_par_en_nxt;
  logic                 w_par_bit_nxt;
  logic                 w_two_stop_nxt;
  logic [DATA_BITS-1:0] w_hold_data_nxt;
  logic                 w_hold_par_en_nxt;
  logic                 w_hold_par_bit_nxt;
  logic                 w_hold_two_stop_nxt;
  logic                 w_hold_full_nxt;
  logic                 w_tx_nxt;
  logic                 w_load_in;
  logic                 w_load_hold;

  logic w_accept;
  logic w_bit_end;
  logic w_frame_end;
  logic w_in_par_bit;

  assign o_ready    = (r_state == c_ST_IDLE) || !r_hold_full;
  assign o_busy     = (r_state != c_ST_IDLE);
  assign o_tx_data  = r_tx;
  assign o_done_bit = w_frame_end;

  assign w_accept     = i_valid && o_ready;
  assign w_bit_end    = i_tick && (r_tick_cnt == c_CNT_LAST);
  assign w_frame_end  = (r_state == c_ST_STOP) && w_bit_end && (!r_two_stop || r_stop_second);
  // Parity is resolved at acceptance so the frame needs no further config.
  assign w_in_par_bit = (^i_data) ^ i_parity_odd;

  always_comb begin
    w_state_nxt         = r_state;
    w_tick_cnt_nxt      = r_tick_cnt;
    w_bit_idx_nxt       = r_bit_idx;
    w_stop_second_nxt   = r_stop_second;
    w_shift_nxt         = r_shift;
    w_par_en_nxt        = r_par_en;
    w_par_bit_nxt       = r_par_bit;
    w_two_stop_nxt      = r_two_stop;
    w_hold_data_nxt     = r_hold_data;
    w_hold_par_en_nxt   = r_hold_par_en;
    w_hold_par_bit_nxt  = r_hold_par_bit;
    w_hold_two_stop_nxt = r_hold_two_stop;
    w_hold_full_nxt     = r_hold_full;
    w_load_in           = 1'b0;
    w_load_hold         = 1'b0;
    w_tx_nxt            = 1'b1;

    if (r_state != c_ST_IDLE && i_tick) begin
      w_tick_cnt_nxt = w_bit_end ? '0 : r_tick_cnt + c_CNT_W'(1);
    end

    case (r_state)
      c_ST_IDLE: begin
        if (w_accept) begin
          w_load_in = 1'b1;
        end
      end
      c_ST_START: begin
        if (w_bit_end) begin
          w_state_nxt   = c_ST_DATA;
          w_bit_idx_nxt = '0;
        end
      end
      c_ST_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
          if (r_bit_idx == c_IDX_LAST) begin
            w_state_nxt       = r_par_en ? c_ST_PARITY : c_ST_STOP;
            w_stop_second_nxt = 1'b0;
          end else begin
            w_bit_idx_nxt = r_bit_idx + c_IDX_W'(1);
          end
        end
      end
      c_ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt       = c_ST_STOP;
          w_stop_second_nxt = 1'b0;
        end
      end
      c_ST_STOP: begin
        if (w_frame_end) begin
          // A word arriving on the closing edge goes straight out, like a held one.
          if (r_hold_full) begin
            w_load_hold = 1'b1;
          end else if (w_accept) begin
            w_load_in = 1'b1;
          end else begin
            w_state_nxt = c_ST_IDLE;
          end
        end else if (w_bit_end) begin
          w_stop_second_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase

    if (w_accept && !w_load_in) begin
      w_hold_data_nxt     = i_data;
      w_hold_par_en_nxt   = i_parity_en;
      w_hold_par_bit_nxt  = w_in_par_bit;
      w_hold_two_stop_nxt = i_two_stop;
      w_hold_full_nxt     = 1'b1;
    end

    if (w_load_in) begin
      w_shift_nxt       = i_data;
      w_par_en_nxt      = i_parity_en;
      w_par_bit_nxt     = w_in_par_bit;
      w_two_stop_nxt    = i_two_stop;
      w_state_nxt       = c_ST_START;
      w_tick_cnt_nxt    = '0;
      w_bit_idx_nxt     = '0;
      w_stop_second_nxt = 1'b0;
    end

    if (w_load_hold) begin
      w_shift_nxt       = r_hold_data;
      w_par_en_nxt      = r_hold_par_en;
      w_par_bit_nxt     = r_hold_par_bit;
      w_two_stop_nxt    = r_hold_two_stop;
      w_hold_full_nxt   = 1'b0;
      w_state_nxt       = c_ST_START;
      w_tick_cnt_nxt    = '0;
      w_bit_idx_nxt     = '0;
      w_stop_second_nxt = 1'b0;
    end

    // The line is registered from the next state so it moves with the state.
    case (w_state_nxt)
      c_ST_START:  w_tx_nxt = 1'b0;
      c_ST_DATA:   w_tx_nxt = w_shift_nxt[0];
      c_ST_PARITY: w_tx_nxt = w_par_bit_nxt;
      default:     w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state         <= c_ST_IDLE;
      r_tick_cnt      <= '0;
      r_bit_idx       <= '0;
      r_stop_second   <= 1'b0;
      r_shift         <= '0;
      r_par_en        <= 1'b0;
      r_par_bit       <= 1'b0;
      r_two_stop      <= 1'b0;
      r_hold_data     <= '0;
      r_hold_par_en   <= 1'b0;
      r_hold_par_bit  <= 1'b0;
      r_hold_two_stop <= 1'b0;
      r_hold_full     <= 1'b0;
      r_tx            <= 1'b1;
    end else begin
      r_state         <= w_state_nxt;
      r_tick_cnt      <= w_tick_cnt_nxt;
      r_bit_idx       <= w_bit_idx_nxt;
      r_stop_second   <= w_stop_second_nxt;
      r_shift         <= w_shift_nxt;
      r_par_en        <= w_par_en_nxt;
      r_par_bit       <= w_par_bit_nxt;
      r_two_stop      <= w_two_stop_nxt;
      r_hold_data     <= w_hold_data_nxt;
      r_hold_par_en   <= w_hold_par_en_nxt;
      r_hold_par_bit  <= w_hold_par_bit_nxt;
      r_hold_two_stop <= w_hold_two_stop_nxt;
      r_hold_full     <= w_hold_full_nxt;
      r_tx            <= w_tx_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_frame
// Brief   : Self-checking bench for uart_tx_frame (8-bit and 5-bit instances).
// Revision: 1.0 - initial release
// ============================================================================

module tb_uart_tx_frame;

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       po;
    logic       ts;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  typedef struct {
    logic [8:0] data;
    int         nbits;
    logic       pe;
    logic       par;
    int         len;
  } sb_t;

  logic clk;
  logic rst_n;
  logic tick8;
  logic tick5;
  int   div5;

  logic [7:0] d8_data;
  logic       d8_valid, d8_pe, d8_po, d8_ts;
  logic       rdy8, busy8, done8, tx8;

  logic [4:0] d5_data;
  logic       d5_valid, d5_pe, d5_po, d5_ts;
  logic       rdy5, busy5, done5, tx5;

  logic mon_sel;
  logic m_tx, m_done;

  sb_t  sb[$];
  vec_t vecs[8];
  int   n_cmp;
  int   n_fail;

  assign m_tx   = mon_sel ? tx5 : tx8;
  assign m_done = mon_sel ? done5 : done8;

  uart_tx_frame #(.DATA_BITS(8), .OVERSAMPLE(16)) u_dut8 (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_tick       (tick8),
    .i_data       (d8_data),
    .i_valid      (d8_valid),
    .i_parity_en  (d8_pe),
    .i_parity_odd (d8_po),
    .i_two_stop   (d8_ts),
    .o_ready      (rdy8),
    .o_busy       (busy8),
    .o_done_bit   (done8),
    .o_tx_data    (tx8)
  );

  uart_tx_frame #(.DATA_BITS(5), .OVERSAMPLE(16)) u_dut5 (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_tick       (tick5),
    .i_data       (d5_data),
    .i_valid      (d5_valid),
    .i_parity_en  (d5_pe),
    .i_parity_odd (d5_po),
    .i_two_stop   (d5_ts),
    .o_ready      (rdy5),
    .o_busy       (busy5),
    .o_done_bit   (done5),
    .o_tx_data    (tx5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick for the 5-bit instance: one pulse every fifth clock.
  initial begin
    tick5 = 1'b0;
    div5  = 0;
    forever begin
      @(posedge clk);
      #2;
      div5  = (div5 == 4) ? 0 : div5 + 1;
      tick5 = (div5 == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic sel, input logic [8:0] d, input logic pe, input logic po,
                      input logic ts, input logic par, input int len, input int nbits);
    int t;
    t = 0;
    if (sel) begin
      d5_data = d[4:0]; d5_pe = pe; d5_po = po; d5_ts = ts; d5_valid = 1'b1;
    end else begin
      d8_data = d[7:0]; d8_pe = pe; d8_po = po; d8_ts = ts; d8_valid = 1'b1;
    end
    while (!(sel ? rdy5 : rdy8) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!(sel ? rdy5 : rdy8)) begin
      chk("accept_timeout", 32'd0, 32'd1);
      d5_valid = 1'b0;
      d8_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back('{d, nbits, pe, par, len});
    @(negedge clk);
    if (sel) d5_valid = 1'b0;
    else     d8_valid = 1'b0;
  endtask

  // Waits for a start bit, samples each bit mid-period, checks the done pulse.
  task automatic check_frame(input int bc, output int gap);
    int          t;
    int          pos;
    int          early;
    logic        at_end;
    logic [15:0] exp_bits;
    logic [15:0] got_bits;
    sb_t         e;
    t = 0;
    gap = -1;
    while (m_tx !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (m_tx !== 1'b0) begin
      chk("start_timeout", 32'd0, 32'd1);
      return;
    end
    gap = t;
    if (sb.size() == 0) begin
      chk("unexpected_frame", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    exp_bits = '0;
    for (int i = 0; i < e.nbits; i++) exp_bits[1+i] = e.data[i];
    pos = 1 + e.nbits;
    if (e.pe) begin
      exp_bits[pos] = e.par;
      pos++;
    end
    for (int i = pos; i < e.len; i++) exp_bits[i] = 1'b1;
    got_bits = '0;
    early    = 0;
    at_end   = 1'b0;
    for (int c = 1; c <= bc * e.len; c++) begin
      if (c > 1) @(negedge clk);
      if (c % bc == bc / 2) got_bits[c/bc] = m_tx;
      if (c == bc * e.len) at_end = m_done;
      else if (m_done) early++;
    end
    chk($sformatf("frame_bits_%0h", e.data), {16'd0, got_bits}, {16'd0, exp_bits});
    chk($sformatf("done_pulse_%0h", e.data), {early[30:0], at_end}, 32'd1);
  endtask

  initial begin
    int   gap1, gap2, cnt, t;
    n_cmp  = 0;
    n_fail = 0;
    mon_sel = 1'b0;
    tick8 = 1'b1;
    d8_data = '0; d8_valid = 1'b0; d8_pe = 1'b0; d8_po = 1'b0; d8_ts = 1'b0;
    d5_data = '0; d5_valid = 1'b0; d5_pe = 1'b0; d5_po = 1'b0; d5_ts = 1'b0;
    rst_n = 1'b0;

    vecs[0] = '{9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0, 10};
    vecs[1] = '{9'h007, 1'b1, 1'b0, 1'b0, 1'b1, 11};
    vecs[2] = '{9'h007, 1'b1, 1'b1, 1'b0, 1'b0, 11};
    vecs[3] = '{9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 11};
    vecs[4] = '{9'h0FF, 1'b0, 1'b0, 1'b1, 1'b0, 11};
    vecs[5] = '{9'h03C, 1'b1, 1'b0, 1'b0, 1'b0, 11};
    vecs[6] = '{9'h003, 1'b1, 1'b1, 1'b1, 1'b1, 12};
    vecs[7] = '{9'h080, 1'b1, 1'b1, 1'b0, 1'b0, 11};

    repeat (3) @(negedge clk);
    chk("reset_tx8",   {31'd0, tx8},   32'd1);
    chk("reset_rdy8",  {31'd0, rdy8},  32'd1);
    chk("reset_busy8", {31'd0, busy8}, 32'd0);
    chk("reset_done8", {31'd0, done8}, 32'd0);
    chk("reset_tx5",   {31'd0, tx5},   32'd1);
    chk("reset_busy5", {31'd0, busy5}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frames; config and data are flipped right after acceptance.
    for (int v = 0; v < 8; v++) begin
      send(1'b0, vecs[v].data, vecs[v].pe, vecs[v].po, vecs[v].ts,
           vecs[v].exp_par, vecs[v].exp_len, 8);
      d8_data = ~d8_data;
      d8_pe   = ~d8_pe;
      d8_po   = ~d8_po;
      d8_ts   = ~d8_ts;
      check_frame(16, gap1);
      @(negedge clk);
      chk($sformatf("idle_after_%0h", vecs[v].data), {30'd0, busy8, tx8}, 32'd1);
    end

    // Back-to-back: second word into hold, third word must stall.
    send(1'b0, 9'h055, 1'b0, 1'b0, 1'b0, 1'b0, 10, 8);
    fork
      begin
        check_frame(16, gap1);
        @(negedge clk);
        check_frame(16, gap2);
        chk("b2b_gap", gap2, 32'd0);
      end
      begin
        send(1'b0, 9'h03C, 1'b0, 1'b0, 1'b0, 1'b0, 10, 8);
        chk("ready_hold_full", {31'd0, rdy8}, 32'd0);
        d8_data  = 8'h99;
        d8_valid = 1'b1;
        cnt = 0;
        repeat (20) begin
          @(negedge clk);
          if (rdy8) cnt++;
        end
        chk("stall_third", cnt, 32'd0);
        d8_valid = 1'b0;
      end
    join
    @(negedge clk);
    chk("idle_after_b2b", {30'd0, busy8, tx8}, 32'd1);

    // Slow baud on the 5-bit instance, aligned so a tick lands on acceptance.
    mon_sel = 1'b1;
    t = 0;
    while (tick5 !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    send(1'b1, 9'h01B, 1'b0, 1'b0, 1'b0, 1'b0, 7, 5);
    check_frame(80, gap1);
    @(negedge clk);
    chk("idle_after_5bit", {30'd0, busy5, tx5}, 32'd1);
    mon_sel = 1'b0;

    // Reset during data bit 3 with the holding register occupied.
    send(1'b0, 9'h055, 1'b0, 1'b0, 1'b0, 1'b0, 10, 8);
    send(1'b0, 9'h03C, 1'b0, 1'b0, 1'b0, 1'b0, 10, 8);
    repeat (70) @(negedge clk);
    chk("pre_reset_tx", {31'd0, tx8}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_tx",   {31'd0, tx8},   32'd1);
    chk("async_reset_rdy",  {31'd0, rdy8},  32'd1);
    chk("async_reset_busy", {31'd0, busy8}, 32'd0);
    chk("async_reset_done", {31'd0, done8}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    chk("reset_hold_done", {30'd0, done8, busy8}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send(1'b0, 9'h0C3, 1'b1, 1'b1, 1'b0, 1'b1, 11, 8);
    check_frame(16, gap1);
    @(negedge clk);
    chk("idle_after_reset_frame", {30'd0, busy8, tx8}, 32'd1);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
